// File: rtl/mips_reg_file.sv
// mips_reg_file: 2^ADDR_W x DATA_W register file, two combinational reads, one clocked write, r0 hardwired to zero
module mips_reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);
  localparam int N = 1 << ADDR_W;
  logic [N-1:0][DATA_W-1:0] regs;
  logic [N-1:0] we;
  // one-hot write enable, gated so an idle write port with X address cannot leak; bit 0 never set
  always_comb we = reg_write ? ((N'(1) << write_reg) & ~N'(1)) : '0;
  // async clear of every register, otherwise commit write_data to the enabled register
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= '0;
    else for (int i = 0; i < N; i++) if (we[i]) regs[i] <= write_data;
  assign read_data1 = (read_reg1 == '0) ? '0 : regs[read_reg1];
  assign read_data2 = (read_reg2 == '0) ? '0 : regs[read_reg2];
endmodule

// File: tb/tb_mips_reg_file.sv
// tb_mips_reg_file: directed self-checking bench for mips_reg_file
module tb_mips_reg_file;
  logic        clk = 0;
  logic        reset = 1;
  logic        reg_write = 0;
  logic [4:0]  write_reg = 0;
  logic [31:0] write_data = 0;
  logic [4:0]  read_reg1 = 0;
  logic [4:0]  read_reg2 = 0;
  logic [31:0] read_data1, read_data2;
  int tests = 0;
  int fails = 0;

  mips_reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_write = 1; write_reg = a; write_data = d;
    @(posedge clk);
    #1 reg_write = 0;
  endtask

  task automatic test_reset;
    reset = 1; reg_write = 1; write_reg = 5; write_data = 32'hDEADBEEF;
    read_reg1 = 5; read_reg2 = 31;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_held rd1=%h rd2=%h want 0 0", read_data1, read_data2);
    end
    @(negedge clk);
    reset = 0; reg_write = 0;
    #1;
    tests++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_release rd1=%h rd2=%h want 0 0", read_data1, read_data2);
    end
  endtask

  task automatic test_gating;
    @(negedge clk);
    reg_write = 0; write_reg = 9; write_data = 32'hCAFE;
    repeat (4) @(posedge clk);
    @(negedge clk);
    write_reg = 'x; write_data = 'x;
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      tests++;
      if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
        fails++;
        $display("FAIL gating r%0d rd1=%h rd2=%h want 0 0", i, read_data1, read_data2);
      end
    end
    write_reg = 0; write_data = 0;
  endtask

  task automatic test_full;
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A50000 + 32'(i));
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      e1 = (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'hA5A50000 + 32'(31 - i);
      #1;
      tests++;
      if (read_data1 !== e1 || read_data2 !== e2) begin
        fails++;
        $display("FAIL full_rb i=%0d rd1=%h rd2=%h want %h %h", i, read_data1, read_data2, e1, e2);
      end
    end
  endtask

  task automatic test_r0;
    wr(0, 32'hFFFFFFFF);
    wr(1, 32'h1234);
    read_reg1 = 0; read_reg2 = 1;
    #1;
    tests++;
    if (read_data1 !== 32'h0) begin
      fails++;
      $display("FAIL r0_protect rd1=%h want 0", read_data1);
    end
    tests++;
    if (read_data2 !== 32'h1234) begin
      fails++;
      $display("FAIL r1_write rd2=%h want 00001234", read_data2);
    end
  endtask

  task automatic test_rdw;
    wr(7, 32'h11);
    @(negedge clk);
    reg_write = 1; write_reg = 7; write_data = 32'h22; read_reg1 = 7;
    #1;
    tests++;
    if (read_data1 !== 32'h11) begin
      fails++;
      $display("FAIL rdw_before rd1=%h want 00000011", read_data1);
    end
    @(posedge clk);
    #1 reg_write = 0;
    tests++;
    if (read_data1 !== 32'h22) begin
      fails++;
      $display("FAIL rdw_after rd1=%h want 00000022", read_data1);
    end
  endtask

  task automatic test_back_to_back;
    read_reg2 = 4;
    @(negedge clk);
    reg_write = 1; write_reg = 4; write_data = 32'hAA;
    @(posedge clk);
    #1;
    tests++;
    if (read_data2 !== 32'hAA) begin
      fails++;
      $display("FAIL b2b_first rd2=%h want 000000aa", read_data2);
    end
    write_data = 32'hBB;
    @(posedge clk);
    #1 reg_write = 0;
    tests++;
    if (read_data2 !== 32'hBB) begin
      fails++;
      $display("FAIL b2b_last rd2=%h want 000000bb", read_data2);
    end
  endtask

  task automatic test_async_reset;
    read_reg1 = 7; read_reg2 = 31;
    @(negedge clk);
    #1;
    tests++;
    if (read_data1 !== 32'h22 || read_data2 !== 32'hA5A5001F) begin
      fails++;
      $display("FAIL pre_pulse rd1=%h rd2=%h want 00000022 a5a5001f", read_data1, read_data2);
    end
    reset = 1;
    #1;
    tests++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL async_clear rd1=%h rd2=%h want 0 0", read_data1, read_data2);
    end
    #1 reset = 0;
    #1;
    tests++;
    if (read_data1 !== 32'h0 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL post_pulse rd1=%h rd2=%h want 0 0", read_data1, read_data2);
    end
    wr(3, 32'h3);
    read_reg1 = 3;
    #1;
    tests++;
    if (read_data1 !== 32'h3 || read_data2 !== 32'h0) begin
      fails++;
      $display("FAIL write_after_pulse rd1=%h rd2=%h want 00000003 0", read_data1, read_data2);
    end
  endtask

  initial begin
    test_reset;
    test_gating;
    test_full;
    test_r0;
    test_rdw;
    test_back_to_back;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_reg_file.md
# mips_reg_file

Architectural register file for the single-cycle MIPS datapath: 2^ADDR_W registers of DATA_W bits, two combinational read ports and one clocked write port. The write port is the receiving end of the 5-bit destination-register select path. The selected register number (rt or rd) is decoded into a one-hot write enable, and write_data is committed on the rising clock edge. Register 0 is hardwired to zero.

## Interface
- DATA_W, default 32: register and data-port width.
- ADDR_W, default 5: register-number width; register count is 2^ADDR_W (32).

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- reg_write  input  1  write enable from the control unit.
- write_reg  input  ADDR_W  destination register number (output of the rt/rd select mux).
- write_data  input  DATA_W  value to commit (output of the ALU/memory result mux).
- read_reg1  input  ADDR_W  source register rs.
- read_reg2  input  ADDR_W  source register rt.
- read_data1  output  DATA_W  contents of register read_reg1.
- read_data2  output  DATA_W  contents of register read_reg2.

## Operation
- Storage: regs[0 .. 2^ADDR_W-1], each DATA_W bits.
- Write decode: write_reg is decoded to a 2^ADDR_W-bit one-hot vector, ANDed with reg_write to give per-register enables we[i].
  - we[0] is forced to 0.
  - At most one enable is active in any cycle.
- Write: at the rising edge of clk, with reset low and we[i]=1, regs[i] <= write_data. All other registers hold their value.
- Writes to register 0 are discarded silently. No error flag is raised.
- Reset: while reset=1, all registers are asynchronously held at 0, independent of clk. A write presented in a cycle where reset is high is dropped.
- Read:
  - read_dataN = regs[read_regN], or 0 when read_regN = 0.
  - Purely combinational.
  - Both ports may address the same register, or the register being written, in the same cycle.
- Read-during-write: no bypass. A read of write_reg in the cycle the write is presented returns the pre-edge value. The new value appears after the rising edge. This matches single-cycle semantics, where the instruction reads operands before its own writeback.
- X handling: if reg_write is 0, write_reg and write_data may be X without corrupting any register.

## Timing
- Reset values: read_data1 = read_data2 = 0 for every read address while reset is high and after its release, until the first write.
- Write latency: 1 edge. Data presented before rising edge k is readable combinationally immediately after edge k.
- Read latency: 0 cycles, combinational from read_regN and register state.
- Reset assert mid-cycle: registers clear immediately. Outputs go to 0 within the same cycle, without waiting for a clock edge.
- Reset deassert: the first rising edge with reset low may perform a write. Reset release is assumed synchronous to clk at the system level.
- Back-to-back writes to the same register on consecutive edges: each edge commits its own write_data, and the last one wins.
- Simultaneous reset and write on the same edge: reset wins and the register stays 0.

## Test plan
- Reset clear: hold reset=1 with reg_write=1, write_reg=5, write_data=32'hDEADBEEF across 3 edges, then release. Required: read_reg1=5 and read_reg2=31 give read_data1 = read_data2 = 0.
- Full write/readback: for i = 1..31, write 32'hA5A50000 + i. Then sweep read_reg1 = i and read_reg2 = 31-i. Required: each read_data equals the value written to its register, and register 0 reads 0.
- Register-0 protection: write write_reg=0, write_data=32'hFFFFFFFF. Required: read_reg1=0 gives read_data1=0. Write register 1 with 32'h1234 in the same test. Required: register 1 reads 32'h1234 and register 0 stays 0.
- Read-during-write: register 7 holds 32'h11. Present a write of 32'h22 to register 7 with read_reg1=7. Required: read_data1=32'h11 before the edge and 32'h22 after it.
- Enable gating: reg_write=0, write_reg=9, write_data=32'hCAFE for 4 edges. Required: register 9 keeps its prior value (0 after reset), and no other register changes.
- Async reset mid-run: populate registers 1..31, then pulse reset high for 2 ns between clock edges. Required: all reads return 0 immediately, with no edge needed. A write on the first edge after release lands correctly, e.g. register 3 = 32'h3.
